// File: rtl/regfile_write_arbiter.sv
// Register file write-port arbiter: pipeline writeback (A) over multi-cycle unit (B).
// Tracks pending B destinations for decode hazards and flags B starvation.
module regfile_write_arbiter #(
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              a_we,
    input  logic [4:0]        a_reg,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    input  logic [4:0]        b_reg,
    input  logic [DATA_W-1:0] b_data,
    output logic              b_ready,
    input  logic              iss_valid,
    input  logic [4:0]        iss_reg,
    input  logic [4:0]        rs_addr,
    input  logic [4:0]        rt_addr,
    output logic              hazard_stall,
    output logic              starve_stall,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    logic             a_act;
    logic             b_fire;
    logic [31:0]      pending;
    logic [31:0]      pending_nxt;
    logic [31:0]      set_mask;
    logic [31:0]      clr_mask;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Arbitration: A always wins; a write to $0 is not a request
    always_comb begin
        a_act   = a_we && (a_reg != 5'd0);
        b_ready = !a_act;
        b_fire  = b_valid && b_ready;
    end

    // Scoreboard next state: clear on B completion, issue set overrides it
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (iss_valid && (iss_reg != 5'd0)) set_mask = 32'd1 << iss_reg;
        if (b_fire) clr_mask = 32'd1 << b_reg;
        pending_nxt = ((pending & ~clr_mask) | set_mask) & ~32'd1;
    end

    // Starvation counter next state: count refused cycles, saturate at limit
    always_comb begin
        cnt_nxt = '0;
        if (b_valid && !b_ready) begin
            cnt_nxt = (cnt == LIMIT) ? cnt : cnt + CNT_W'(1);
        end
    end

    // Stall outputs come from registered state only
    always_comb begin
        hazard_stall = ((rs_addr != 5'd0) && pending[rs_addr]) ||
                       ((rt_addr != 5'd0) && pending[rt_addr]);
        starve_stall = (cnt == LIMIT);
    end

    // Scoreboard and starvation counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
            cnt     <= '0;
        end else begin
            pending <= pending_nxt;
            cnt     <= cnt_nxt;
        end
    end

    // Registered write port; address/data hold when no write
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (a_act) begin
            rf_we    <= 1'b1;
            rf_waddr <= a_reg;
            rf_wdata <= a_data;
        end else if (b_fire && (b_reg != 5'd0)) begin
            rf_we    <= 1'b1;
            rf_waddr <= b_reg;
            rf_wdata <= b_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the register file's single write port between two writeback sources.
  - Source A: the in-order pipeline writeback. It has absolute priority and no backpressure.
  - Source B: a multi-cycle execution unit (mult/div). It uses a valid/ready handshake.
- Keeps a 32-entry pending scoreboard of B destinations and raises a stall when decode reads a pending register.
- Sits between the pipeline's WB stage, the multi-cycle unit and the register file write inputs.

Parameters:
- DATA_W, 32, width of write data.
- STARVE_LIMIT, 4, number of consecutive refused B cycles before starve_stall asserts (range 1..255).
- CNT_W, 8, width of the starvation counter; must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- a_we  in  1  pipeline writeback request.
- a_reg  in  5  pipeline destination register.
- a_data  in  DATA_W  pipeline write data.
- b_valid  in  1  multi-cycle result valid.
- b_reg  in  5  multi-cycle destination register.
- b_data  in  DATA_W  multi-cycle result data.
- b_ready  out  1  B result accepted this cycle.
- iss_valid  in  1  multi-cycle op issued this cycle.
- iss_reg  in  5  destination register of the issued op.
- rs_addr  in  5  decode source register 1.
- rt_addr  in  5  decode source register 2.
- hazard_stall  out  1  a decode source is pending.
- starve_stall  out  1  request that the pipeline frees the next A slot.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  DATA_W  register file write data.

Behaviour:
- Reset (reset=0, asynchronous): all registered state clears.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - pending=0, starve counter=0.
  - Consequently b_ready=1 (no A activity), hazard_stall=0, starve_stall=0.
- Assertion of reset mid-operation discards any in-flight write and all pending bits; nothing is replayed.
- a_act = a_we && (a_reg != 0).
  - A write to $0 is never a request and never reaches the register file.
- Arbitration (combinational, every cycle):
  - b_ready = !a_act. It does not depend on b_valid.
  - A B handshake fires when b_valid && b_ready.
- Write port (registered, 1-cycle latency). On each clk edge:
  - if a_act: rf_we=1, rf_waddr=a_reg, rf_wdata=a_data.
  - else if B handshake with b_reg != 0: rf_we=1, rf_waddr=b_reg, rf_wdata=b_data.
  - else: rf_we=0, and rf_waddr/rf_wdata hold their previous values.
- A B handshake with b_reg=0 is accepted and discarded (rf_we=0).
- A is never dropped or delayed, including while starve_stall=1.
- Scoreboard pending[31:0], updated on the clk edge:
  - iss_valid && iss_reg != 0 sets pending[iss_reg].
  - A B handshake clears pending[b_reg].
  - If the set and the clear target the same register in the same cycle, set wins.
  - pending[0] is always 0.
  - Issuing to an already-pending register leaves its bit set (no count).
- hazard_stall = (rs_addr != 0 && pending[rs_addr]) || (rt_addr != 0 && pending[rt_addr]).
  - Evaluated from the registered scoreboard only.
  - A same-cycle issue does not raise it until the next cycle.
  - A same-cycle clear does not drop it until the next cycle.
- Starvation counter:
  - Increments when b_valid && !b_ready, saturating at STARVE_LIMIT.
  - Clears to 0 on a B handshake or whenever b_valid=0.
  - starve_stall = (counter == STARVE_LIMIT), combinational from the counter.
  - Deasserts the cycle after the B handshake completes.
- b_data and b_reg must remain stable while b_valid && !b_ready. The block does not buffer B.

Test Plan:
- Reset released, no traffic -> rf_we=0, b_ready=1, hazard_stall=0, starve_stall=0; assert reset again mid-traffic -> all outputs return to these values immediately.
- a_we=1, a_reg=5, a_data=0x1234, with b_valid=1, b_reg=7 on the same cycle -> b_ready=0; next cycle rf_we=1, rf_waddr=5, rf_wdata=0x1234; A idle next cycle -> B accepted, following cycle rf_waddr=7.
- iss_valid=1, iss_reg=9; next cycle rs_addr=9 -> hazard_stall=1; B handshake with b_reg=9 -> hazard_stall=0 one cycle later; rt_addr=0 never stalls.
- iss_valid=1, iss_reg=3, same cycle as a B handshake with b_reg=3 (pending[3]=1 beforehand) -> pending[3] remains 1.
- A active continuously with b_valid=1, STARVE_LIMIT=4 -> starve_stall=1 from the 5th refused cycle onward; drop a_we -> B handshake, starve_stall=0 the next cycle.
- a_we=1, a_reg=0 and b_valid=1, b_reg=0 -> b_ready=1, rf_we stays 0, scoreboard unchanged.
